sweep_ctrl: RTL and testbench

//  Frequency-sweep sequencer for the frequency response detector.

---
 rtl/sweep_ctrl.sv | 122 ++++++++++++
 tb/tb_sweep_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS frequency word over N points and
// waits for a settle time and a measurement handshake at each point.
module sweep_ctrl #(
  parameter int FWORD_W  = 32,
  parameter int NPTS_W   = 16,
  parameter int SETTLE_W = 24,
  parameter int MEAS_TO  = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [FWORD_W-1:0]  start_fword,
  input  logic [FWORD_W-1:0]  step_fword,
  input  logic [NPTS_W-1:0]   num_points,
  input  logic [SETTLE_W-1:0] settle_cyc,
  output logic                param_wen,
  output logic [FWORD_W-1:0]  phase_fword,
  output logic                meas_start,
  input  logic                meas_done,
  output logic                point_valid,
  output logic [NPTS_W-1:0]   point_idx,
  output logic                point_to,
  output logic                busy,
  output logic                done
);

  localparam int MEAS_W = (MEAS_TO > 1) ? $clog2(MEAS_TO) : 1;
  localparam logic [MEAS_W-1:0] MEAS_LAST = MEAS_W'(MEAS_TO > 0 ? MEAS_TO - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_MEAS, S_NEXT, S_FIN
  } state_t;

  state_t              state, nxt;
  logic [FWORD_W-1:0]  cur, step_q, last_fw;
  logic [NPTS_W-1:0]   npts_q, idx;
  logic [SETTLE_W-1:0] settle_q, scnt;
  logic [MEAS_W-1:0]   mcnt;
  logic                ms_seen, to_q;
  logic                accept, last_pt, meas_to_hit;

  assign accept      = (state == S_IDLE) && start && !abort;
  assign last_pt     = (idx == npts_q - 1'b1);
  assign meas_to_hit = (MEAS_TO != 0) && (mcnt == MEAS_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (accept) nxt = (num_points == '0) ? S_FIN : S_LOAD;
      S_LOAD:   nxt = S_SETTLE;
      S_SETTLE: if (scnt <= SETTLE_W'(1)) nxt = S_MEAS;
      S_MEAS:   if (meas_done || meas_to_hit) nxt = S_NEXT;
      S_NEXT:   nxt = last_pt ? S_FIN : S_LOAD;
      S_FIN:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) nxt = S_IDLE;
  end

  // Sweep parameters are frozen at accept; later input changes are invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= '0;
      step_q   <= '0;
      last_fw  <= '0;
      npts_q   <= '0;
      idx      <= '0;
      settle_q <= '0;
      scnt     <= '0;
      mcnt     <= '0;
      ms_seen  <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cur      <= start_fword;
          step_q   <= step_fword;
          npts_q   <= num_points;
          settle_q <= (settle_cyc == '0) ? SETTLE_W'(1) : settle_cyc;
          idx      <= '0;
          to_q     <= 1'b0;
        end
        S_LOAD: begin
          last_fw <= cur;
          scnt    <= settle_q;
          mcnt    <= '0;
          ms_seen <= 1'b0;
        end
        S_SETTLE: scnt <= scnt - 1'b1;
        S_MEAS: begin
          ms_seen <= 1'b1;
          to_q    <= !meas_done;
          if (MEAS_TO != 0) mcnt <= mcnt + 1'b1;
        end
        S_NEXT: if (!last_pt) begin
          idx <= idx + 1'b1;
          cur <= cur + step_q;
        end
        default: ;
      endcase
    end
  end

  // An abort landing in NEXT or FIN suppresses that cycle's report.
  always_comb begin
    param_wen   = (state == S_LOAD);
    phase_fword = param_wen ? cur : last_fw;
    meas_start  = (state == S_MEAS) && !ms_seen;
    point_valid = (state == S_NEXT) && !abort;
    point_to    = point_valid && to_q;
    point_idx   = idx;
    busy        = (state != S_IDLE);
    done        = (state == S_FIN) && !abort;
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl: expected words, gaps and point reports are
// queued when a sweep is launched and checked as the DUT emits them.
module tb_sweep_ctrl;
  localparam int FW = 32, NW = 16, SW = 24, TO = 50;

  logic          clk = 1'b0, rst;
  logic          start, abort, meas_done;
  logic [FW-1:0] start_fword, step_fword, phase_fword;
  logic [NW-1:0] num_points, point_idx;
  logic [SW-1:0] settle_cyc;
  logic          param_wen, meas_start, point_valid, point_to, busy, done;

  always #5 clk = ~clk;

  sweep_ctrl #(.FWORD_W(FW), .NPTS_W(NW), .SETTLE_W(SW), .MEAS_TO(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .start_fword(start_fword), .step_fword(step_fword),
    .num_points(num_points), .settle_cyc(settle_cyc),
    .param_wen(param_wen), .phase_fword(phase_fword),
    .meas_start(meas_start), .meas_done(meas_done),
    .point_valid(point_valid), .point_idx(point_idx), .point_to(point_to),
    .busy(busy), .done(done)
  );

  int vectors = 0, miscompares = 0, cyc = 0;
  int wen_cnt = 0, done_cnt = 0, done_exp = 0, s_cyc = 0;
  int last_wen_cyc = 0, last_ms_cyc = 0, last_md_cyc = 0, last_pv_cyc = 0, last_done_cyc = 0;
  bit resp_en = 1'b1;
  int resp_dly = 5;
  logic [FW-1:0] wen_q[$];
  int            gap_q[$];
  logic [NW:0]   pv_q[$];   // {timed_out, idx}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor / scoreboard consumer
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (meas_done) last_md_cyc = cyc;
      if (param_wen) begin
        wen_cnt++;
        last_wen_cyc = cyc;
        if (wen_q.size() == 0) chk("unexpected param_wen", 64'(1), 64'(0));
        else chk("phase_fword", 64'(phase_fword), 64'(wen_q.pop_front()));
      end
      if (meas_start) begin
        last_ms_cyc = cyc;
        if (gap_q.size() == 0) chk("unexpected meas_start", 64'(1), 64'(0));
        else chk("param_wen_to_meas_start", 64'(cyc - last_wen_cyc), 64'(gap_q.pop_front()));
      end
      if (point_valid) begin
        last_pv_cyc = cyc;
        if (pv_q.size() == 0) chk("unexpected point_valid", 64'(1), 64'(0));
        else begin
          logic [NW:0] e;
          e = pv_q.pop_front();
          chk("point_idx", 64'(point_idx), 64'(e[NW-1:0]));
          chk("point_to", 64'(point_to), 64'(e[NW]));
          if (e[NW]) chk("meas_start_to_timeout", 64'(cyc - last_ms_cyc), 64'(TO));
          else       chk("meas_done_to_point_valid", 64'(cyc - last_md_cyc), 64'(1));
        end
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  // Measurement block model: answers each meas_start after resp_dly cycles
  initial begin
    meas_done = 1'b0;
    forever begin
      @(negedge clk);
      if (meas_start && resp_en) begin
        repeat (resp_dly) @(posedge clk);
        #1 meas_done = 1'b1;
        @(posedge clk);
        #1 meas_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic push_sweep(input logic [FW-1:0] sf, input logic [FW-1:0] st,
                            input int np, input int sc, input bit to);
    logic [FW-1:0] w;
    w = sf;
    for (int i = 0; i < np; i++) begin
      wen_q.push_back(w);
      gap_q.push_back(((sc == 0) ? 1 : sc) + 1);
      pv_q.push_back({to, NW'(i)});
      w = w + st;
    end
  endtask

  task automatic do_start(input logic [FW-1:0] sf, input logic [FW-1:0] st,
                          input int np, input int sc);
    @(posedge clk); #1;
    start_fword = sf; step_fword = st;
    num_points = NW'(np); settle_cyc = SW'(sc);
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string t, input int maxc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({t, " sweep ends (busy)"}, 64'(busy), 64'(0));
  endtask

  task automatic end_checks(input string t);
    chk({t, " leftover expectations"}, 64'(wen_q.size() + gap_q.size() + pv_q.size()), 64'(0));
    chk({t, " done count"}, 64'(done_cnt), 64'(done_exp));
    wen_q.delete(); gap_q.delete(); pv_q.delete();
  endtask

  initial begin
    int n, base;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start_fword = '0; step_fword = '0; num_points = '0; settle_cyc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset strobes", 64'({param_wen, meas_start, point_valid, point_to, busy, done}), 64'(0));
    chk("reset phase_fword", 64'(phase_fword), 64'(0));
    chk("reset point_idx", 64'(point_idx), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // T1: basic 3-point sweep
    push_sweep(100, 10, 3, 4, 1'b0); done_exp++;
    do_start(100, 10, 3, 4);
    chk("T1 start_to_param_wen", 64'(param_wen), 64'(1));
    wait_idle("T1", 500);
    chk("T1 point_valid_to_done", 64'(last_done_cyc - last_pv_cyc), 64'(1));
    chk("T1 phase_fword hold", 64'(phase_fword), 64'(120));
    chk("T1 point_idx hold", 64'(point_idx), 64'(2));
    end_checks("T1");

    // T2: settle 0 and 1 both give a 2-cycle gap
    push_sweep(7, 1, 1, 0, 1'b0); done_exp++;
    do_start(7, 1, 1, 0);
    wait_idle("T2a", 200);
    end_checks("T2a");
    push_sweep(9, 1, 1, 1, 1'b0); done_exp++;
    do_start(9, 1, 1, 1);
    wait_idle("T2b", 200);
    end_checks("T2b");

    // T3: zero points
    done_exp++;
    do_start(5, 5, 0, 3);
    wait_idle("T3", 20);
    chk("T3 start_to_done", 64'(last_done_cyc - s_cyc), 64'(1));
    end_checks("T3");

    // T4: wraparound, with a start and input changes while busy
    push_sweep(32'hFFFF_FFF8, 16, 2, 2, 1'b0); done_exp++;
    do_start(32'hFFFF_FFF8, 16, 2, 2);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; start_fword = 32'h1234; step_fword = 1; num_points = 9; settle_cyc = 0;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("T4", 300);
    end_checks("T4");

    // T5a: abort during SETTLE of point 1
    wen_q.push_back(100); wen_q.push_back(110);
    gap_q.push_back(21);
    pv_q.push_back({1'b0, NW'(0)});
    base = wen_cnt;
    do_start(100, 10, 3, 20);
    n = 0;
    while (wen_cnt < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("T5a reached point 1", 64'(wen_cnt - base), 64'(2));
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("T5a abort to idle", 64'(busy), 64'(0));
    repeat (40) @(negedge clk);
    chk("T5a phase_fword hold", 64'(phase_fword), 64'(110));
    end_checks("T5a");

    // T5b: abort coincident with meas_done
    wen_q.push_back(200); gap_q.push_back(3);
    do_start(200, 1, 2, 2);
    n = 0;
    @(negedge clk);
    while (!meas_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("T5b meas_done seen", 64'(meas_done), 64'(1));
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("T5b abort to idle", 64'(busy), 64'(0));
    repeat (20) @(negedge clk);
    end_checks("T5b");

    // start together with abort in IDLE is ignored
    @(posedge clk); #1 start = 1'b1; abort = 1'b1; num_points = 1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start+abort ignored", 64'(busy), 64'(0));
    repeat (10) @(negedge clk);
    end_checks("T5 idle");

    // T5c: normal sweep after aborts
    push_sweep(50, 5, 2, 3, 1'b0); done_exp++;
    do_start(50, 5, 2, 3);
    wait_idle("T5c", 300);
    end_checks("T5c");

    // T6: answers arrive after the timeout (during SETTLE, then in IDLE)
    resp_dly = 60;
    push_sweep(1000, 1, 2, 30, 1'b1); done_exp++;
    do_start(1000, 1, 2, 30);
    wait_idle("T6", 400);
    repeat (80) @(negedge clk);
    end_checks("T6");
    resp_dly = 5;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
